bcd_updown_counter_n: RTL

//  Multi-digit BCD up/down counter with built-in prescaler, synchronous load,

---
 rtl/bcd_updown_counter_n.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit packed-BCD up/down counter with enable prescaler, synchronous clamped load,
// wrap/saturate boundary mode and a registered one-cycle terminal-count pulse.
module bcd_updown_counter_n #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1,
  parameter int PW       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                ud_i,
  input  logic                sat_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  output logic [4*DIGITS-1:0] q_o,
  output logic                tick_o,
  output logic                tc_o
);

  localparam int              W         = 4 * DIGITS;
  localparam logic [PW-1:0]   PRES_LAST = PW'(PRESCALE - 1);
  localparam logic [W-1:0]    MAX_BCD   = {DIGITS{4'h9}};

  logic [W-1:0]  q_q, q_d;
  logic [PW-1:0] pres_q, pres_d;
  logic          tc_q, tc_d;
  logic          at_max, at_min, tick;

  // Out-of-range nibbles become 9 so an illegal BCD code can never be stored.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] step_up(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    at_max = 1'b1;
    at_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (q_q[4*i +: 4] != 4'd9) at_max = 1'b0;
      if (q_q[4*i +: 4] != 4'd0) at_min = 1'b0;
    end
  end

  assign tick = en_i & (pres_q == PRES_LAST) & ~load_i;

  // NOTE: every next-state signal gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    q_d    = q_q;
    pres_d = pres_q;
    tc_d   = 1'b0;
    if (load_i) begin
      q_d    = clamp_bcd(load_val_i);
      pres_d = '0;
    end else if (en_i) begin
      pres_d = (pres_q == PRES_LAST) ? '0 : pres_q + PW'(1);
      if (tick) begin
        if (ud_i) begin
          if (at_max) begin
            tc_d = 1'b1;
            q_d  = sat_i ? q_q : '0;
          end else begin
            q_d  = step_up(q_q);
          end
        end else begin
          if (at_min) begin
            tc_d = 1'b1;
            q_d  = sat_i ? q_q : MAX_BCD;
          end else begin
            q_d  = step_down(q_q);
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      pres_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      pres_q <= pres_d;
      tc_q   <= tc_d;
    end
  end

  assign q_o    = q_q;
  assign tick_o = tick;
  assign tc_o   = tc_q;

endmodule
